ma_filter_param: RTL and testbench
==================================

Name: ma_filter_param

Overview:
Parametrised, runtime-configurable moving-average FIR. It generalises the fixed 8-tap MA filter to any data width and any power-of-two window up to 2^LOG2_TAPS_MAX. It uses a running-sum plus circular-buffer architecture, with valid qualification on both input and output. It sits in the sample datapath between the sample source and downstream DSP stages.

Parameters:
DATA_W, 16, signed sample width of d and q.
LOG2_TAPS_MAX, 3, log2 of the maximum window length; buffer depth is DEPTH = 2^LOG2_TAPS_MAX.
WSEL_W, $clog2(LOG2_TAPS_MAX+1), width of win_sel (derived; do not override).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  synchronous, active-low reset.
clear  input  1  synchronous flush; also reloads the window setting.
win_sel  input  WSEL_W  log2 of the window length; sampled only at reset or clear.
in_valid  input  1  d carries a new sample this cycle.
d  input  DATA_W  signed input sample.
out_valid  output  1  q was updated this cycle (one-cycle pulse per accepted sample).
q  output  DATA_W  signed filtered output, registered.
full  output  1  window has been completely filled since the last reset or clear.

Behaviour:
- State registers:
  - buffer[DEPTH] of DATA_W; never cleared.
  - wr_ptr, LOG2_TAPS_MAX bits.
  - fill_cnt, saturating at 2^k.
  - sum, signed DATA_W+LOG2_TAPS_MAX bits.
  - k, the latched window log2.
- Reset (reset_n=0 at a clk edge):
  - wr_ptr=0, fill_cnt=0, sum=0, q=0, out_valid=0, full=0.
  - k = min(win_sel, LOG2_TAPS_MAX).
  - Reset has priority over every other input.
- clear=1: identical effect to reset, including reloading k. A concurrent in_valid sample is dropped.
- win_sel changes while clear=0 and reset_n=1 are ignored.
- Accepted sample (in_valid=1, no reset or clear):
  - oldest = (fill_cnt == 2^k) ? buffer[wr_ptr - 2^k mod DEPTH] : 0.
  - sum_next = sum + sext(d) - sext(oldest).
  - buffer[wr_ptr] = d; wr_ptr increments mod DEPTH; fill_cnt increments, saturating at 2^k.
  - q = (sum_next >>> k), truncated to DATA_W (arithmetic shift, floor toward -inf); out_valid=1.
- Unfilled window: slots not yet written count as zero (zero-padded start, same as the fixed 8-tap block).
- full:
  - Asserts on the edge where fill_cnt reaches 2^k.
  - Stays high until reset or clear.
  - With k=0 it asserts on the first sample.
- Latency: q and out_valid update on the same edge that accepts d (1 cycle). No throughput limit; one sample per cycle is sustained.
- in_valid=0: sum, pointers, buffer and q hold; out_valid=0.
- Widths:
  - sum cannot overflow: |sum| <= 2^k * 2^(DATA_W-1).
  - q is always within the DATA_W range, so no saturation logic is needed.
- k=0: pass-through with 1-cycle latency.
- Wrap: wr_ptr wraps silently at DEPTH. The read index is computed mod DEPTH.

Optional Feature:
MA_FILTER_ROUND_EN
- Defined: q = (sum_next + (k>0 ? 2^(k-1) : 0)) >>> k, i.e. round-half-up.
  - The addition is done at sum width + 1.
  - The result is clamped to the maximum positive value if it exceeds it.
- Undefined: truncation (floor) as described in Behaviour.
- Latency and interface are identical in both builds.

Test Plan:
1. Step, k=3 (window 8), d=0x7FFF held with in_valid=1 after reset.
   - q sequence: 0x0FFF, 0x1FFF, 0x2FFF, ... 0x7FFF on the 8th sample, then holds 0x7FFF.
   - full rises with the 8th out_valid.
   - With ROUND_EN the first q is 0x1000.
2. Impulse, k=3: one sample 0x7FFF, then zeros.
   - q=0x0FFF for exactly 8 outputs, then 0x0000.
   - sum returns to 0.
3. Negative floor, k=1: d=0xFFFF (-1) twice.
   - q=0xFFFF both times (floor); with ROUND_EN q=0x0000, then 0xFFFF.
4. Bubbles: k=2, d=4,8,12,16 with in_valid toggling 1,0,1,0...
   - out_valid only on accepted samples; q = 1, 3, 6, 10; q holds between them.
5. Clear mid-run with window change: run k=3 with d=0x1000 for 5 samples.
   - Assert clear with win_sel=2 and in_valid=1: that sample is dropped; q=0, full=0.
   - Next d=0x1000 samples: q=0x0400, 0x0800, 0x0C00, 0x1000; full on the 4th.
6. Reset priority and wrap: hold reset_n=0 with in_valid=1 for 3 cycles → q=0, out_valid=0.
   - Then k=0 with 20 random samples: q equals d delayed by 1 cycle, including across wr_ptr wrap.

Source files
------------

// File: rtl/ma_filter_param.sv
// Runtime-configurable moving-average filter: running sum over a power-of-two
// window held in a circular buffer. Define MA_FILTER_ROUND_EN for round-half-up output.
module ma_filter_param #(
    parameter int DATA_W        = 16,
    parameter int LOG2_TAPS_MAX = 3,
    parameter int WSEL_W        = $clog2(LOG2_TAPS_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [WSEL_W-1:0] win_sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] d,
    output logic              out_valid,
    output logic [DATA_W-1:0] q,
    output logic              full
);

    localparam int DEPTH = 1 << LOG2_TAPS_MAX;
    localparam int SUM_W = DATA_W + LOG2_TAPS_MAX;
    localparam int CNT_W = LOG2_TAPS_MAX + 1;
    localparam int PTR_W = LOG2_TAPS_MAX;

    logic [DATA_W-1:0]       buf_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0]       q_q, q_d;
    logic                    out_valid_q;
    logic                    full_q;
    logic [WSEL_W-1:0]       k_q, k_load;

    logic [CNT_W-1:0]        win_len;
    logic                    win_full;
    logic [PTR_W-1:0]        rd_idx;
    logic [DATA_W-1:0]       oldest;
    logic                    flush;

    assign flush = !reset_n || clear;

    // Window settings above the buffer depth fall back to the largest window.
    always_comb begin
        k_load = win_sel;
        if (32'(win_sel) > LOG2_TAPS_MAX)
            k_load = WSEL_W'(LOG2_TAPS_MAX);
    end

    always_comb begin
        win_len  = CNT_W'(1) << k_q;
        win_full = (fill_q == win_len);
        // Only the low bits of the window length matter for the modulo-DEPTH read.
        rd_idx   = wr_ptr_q - win_len[PTR_W-1:0];
        oldest   = win_full ? buf_q[rd_idx] : '0;
        sum_d    = sum_q
                 + {{LOG2_TAPS_MAX{d[DATA_W-1]}}, d}
                 - {{LOG2_TAPS_MAX{oldest[DATA_W-1]}}, oldest};
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        fill_d   = win_full ? fill_q : fill_q + CNT_W'(1);
    end

`ifdef MA_FILTER_ROUND_EN
    localparam logic [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W:0] Q_MAX_W = {{(SUM_W-DATA_W+1){1'b0}}, Q_MAX};

    logic signed [SUM_W:0] half, rnd_sum, rnd_shf;

    // One extra bit of headroom so the rounding offset cannot wrap the sum.
    always_comb begin
        half    = '0;
        if (k_q != '0)
            half = (SUM_W+1)'(1) << (k_q - WSEL_W'(1));
        rnd_sum = {sum_d[SUM_W-1], sum_d} + half;
        rnd_shf = rnd_sum >>> k_q;
        q_d     = (rnd_shf > Q_MAX_W) ? Q_MAX : DATA_W'(rnd_shf);
    end
`else
    always_comb begin
        q_d = DATA_W'(sum_d >>> k_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            k_q         <= k_load;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                wr_ptr_q <= wr_ptr_d;
                fill_q   <= fill_d;
                sum_q    <= sum_d;
                q_q      <= q_d;
                full_q   <= full_q || (fill_d == win_len);
            end
        end
    end

    // Sample storage is never flushed; the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (!flush && in_valid)
            buf_q[wr_ptr_q] <= d;
    end

    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign full      = full_q;

endmodule

// File: tb/tb_ma_filter_param.sv
// Directed-vector bench for ma_filter_param (DATA_W=16, window up to 8).
module tb_ma_filter_param;

    localparam int DW = 16;
    localparam int WW = 2;
`ifdef MA_FILTER_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n, clear, in_valid;
    logic [WW-1:0] win_sel;
    logic [DW-1:0] d;
    logic          out_valid, full;
    logic [DW-1:0] q;

    always #5 clk = ~clk;

    ma_filter_param #(.DATA_W(DW), .LOG2_TAPS_MAX(3)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .win_sel(win_sel),
        .in_valid(in_valid), .d(d), .out_valid(out_valid), .q(q), .full(full)
    );

    typedef struct {
        string         name;
        logic          rst_n;
        logic          clr;
        logic [WW-1:0] wsel;
        logic          vld;
        logic [DW-1:0] din;
        logic          e_ov;
        logic [DW-1:0] e_q;
        logic          e_full;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(string name, logic rst_n, logic clr, logic [WW-1:0] wsel,
                                logic vld, logic [DW-1:0] din,
                                logic e_ov, logic [DW-1:0] e_q, logic e_full);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.clr = clr; v.wsel = wsel; v.vld = vld;
        v.din = din; v.e_ov = e_ov; v.e_q = e_q; v.e_full = e_full;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        reset_n  = v.rst_n;
        clear    = v.clr;
        win_sel  = v.wsel;
        in_valid = v.vld;
        d        = v.din;
        @(posedge clk);
        #1;
        check({v.name, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
        check({v.name, ".q"},         32'(q),         32'(v.e_q));
        check({v.name, ".full"},      32'(full),      32'(v.e_full));
    endtask

    initial begin
        vec_t           v;
        logic [DW-1:0]  r;
        logic [DW-1:0]  sv;

        reset_n = 1'b0; clear = 1'b0; win_sel = '0; in_valid = 1'b0; d = '0;

        // 1: step 0x7FFF, window 8
        add("step_rst", 0, 0, 3, 0, 16'h0, 0, 16'h0, 0);
        for (int n = 1; n <= 10; n++) begin
            sv = (n >= 8) ? 16'h7FFF : (RND ? DW'(n << 12) : DW'((n << 12) - 1));
            add($sformatf("step%0d", n), 1, 0, 3, 1, 16'h7FFF, 1, sv, n >= 8);
        end
        // 2: impulse, window 8
        add("imp_rst", 0, 0, 3, 0, 16'h0, 0, 16'h0, 0);
        for (int n = 1; n <= 10; n++)
            add($sformatf("imp%0d", n), 1, 0, 3, 1, (n == 1) ? 16'h7FFF : 16'h0, 1,
                (n <= 8) ? (RND ? 16'h1000 : 16'h0FFF) : 16'h0, n >= 8);
        // 3: negative floor, window 2
        add("neg_rst", 0, 0, 1, 0, 16'h0, 0, 16'h0, 0);
        add("neg1", 1, 0, 1, 1, 16'hFFFF, 1, RND ? 16'h0000 : 16'hFFFF, 0);
        add("neg2", 1, 0, 1, 1, 16'hFFFF, 1, 16'hFFFF, 1);
        // 4: bubbles, window 4
        add("bub_rst", 0, 0, 2, 0, 16'h0, 0, 16'h0, 0);
        add("bub1", 1, 0, 2, 1, 16'd4,    1, 16'd1,  0);
        add("bub2", 1, 0, 2, 0, 16'h7777, 0, 16'd1,  0);
        add("bub3", 1, 0, 2, 1, 16'd8,    1, 16'd3,  0);
        add("bub4", 1, 0, 2, 0, 16'h7777, 0, 16'd3,  0);
        add("bub5", 1, 0, 2, 1, 16'd12,   1, 16'd6,  0);
        add("bub6", 1, 0, 2, 0, 16'h7777, 0, 16'd6,  0);
        add("bub7", 1, 0, 2, 1, 16'd16,   1, 16'd10, 1);
        add("bub8", 1, 0, 2, 0, 16'h7777, 0, 16'd10, 1);
        // 5: clear mid-run reloads window; win_sel changes without clear are ignored
        add("clr_rst", 0, 0, 3, 0, 16'h0, 0, 16'h0, 0);
        for (int n = 1; n <= 5; n++)
            add($sformatf("clr_pre%0d", n), 1, 0, 3, 1, 16'h1000, 1, DW'(n * 16'h0200), 0);
        add("clr_hit", 1, 1, 2, 1, 16'h1000, 0, 16'h0, 0);
        for (int n = 1; n <= 5; n++)
            add($sformatf("clr_post%0d", n), 1, 0, 0, 1, 16'h1000, 1,
                (n >= 4) ? 16'h1000 : DW'(n * 16'h0400), n >= 4);
        // 6a: reset beats valid input and clear
        for (int n = 1; n <= 3; n++)
            add($sformatf("rst_pri%0d", n), 0, n == 2, 0, 1, 16'h1234, 0, 16'h0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // 6b: window 1 is a one-cycle delay, across pointer wrap
        v.rst_n = 1; v.clr = 0; v.wsel = 3; v.vld = 1; v.e_ov = 1; v.e_full = 1;
        r = '0;
        for (int n = 0; n < 20; n++) begin
            r = DW'($urandom);
            v.name = $sformatf("k0_%0d", n); v.din = r; v.e_q = r;
            apply(v);
        end
        v.name = "k0_idle"; v.vld = 0; v.din = 16'h5A5A; v.e_ov = 0; v.e_q = r;
        apply(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule
